// File: rtl/order_queue_ctrl.sv
// order_queue_ctrl
// Pointer and handshake controller for the instruction order-queue register file.
// Turns dispatch pushes and commit pops into memory write/read controls. Each
// accepted pop returns its tag one cycle later. Also keeps full/empty/count
// status and sticky misuse flags.
//
// Ports:
//   clock, reset    rising-edge clock; synchronous active-low reset
//   flush           empties the queue; a push or pop in this cycle is ignored
//   push, push_tag  enqueue request and tag; push_ready = !full
//   pop             dequeue request
//   pop_valid       registered; pop_tag holds the dequeued tag (0 otherwise)
//   full, empty     count == DEPTH / count == 0
//   count           occupied entries, 0..DEPTH
//   err_overflow    sticky; set by a push while full
//   err_underflow   sticky; set by a pop while empty
//   mem_we, mem_dest, mem_wdata   memory write port
//   mem_source, mem_rdata         memory read address and registered read data
module order_queue_ctrl #(
  parameter int unsigned WIDTH        = 5,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned PTRWIDTH     = 5,
  parameter int unsigned ADDRESSWIDTH = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_tag,
  output logic                    push_ready,
  input  logic                    pop,
  output logic                    pop_valid,
  output logic [WIDTH-1:0]        pop_tag,
  output logic                    full,
  output logic                    empty,
  output logic [ADDRESSWIDTH-1:0] count,
  output logic                    err_overflow,
  output logic                    err_underflow,
  output logic                    mem_we,
  output logic [ADDRESSWIDTH-1:0] mem_dest,
  output logic [WIDTH-1:0]        mem_wdata,
  output logic [ADDRESSWIDTH-1:0] mem_source,
  input  logic [WIDTH-1:0]        mem_rdata
);

  logic [PTRWIDTH-1:0] head;
  logic [PTRWIDTH-1:0] tail;
  logic                pushAcc;
  logic                popAcc;

  // Status is decoded from registered count only.
  assign full       = (count == ADDRESSWIDTH'(DEPTH));
  assign empty      = (count == '0);
  assign push_ready = ~full;

  assign pushAcc = push & ~full & ~flush;
  assign popAcc  = pop & ~empty & ~flush;

  assign mem_we     = pushAcc;
  assign mem_wdata  = push_tag;
  assign mem_dest   = {{(ADDRESSWIDTH - PTRWIDTH){1'b0}}, tail};
  assign mem_source = {{(ADDRESSWIDTH - PTRWIDTH){1'b0}}, head};

  // The memory registers rf[head] on the same edge that accepts the pop, so
  // the data lines up with pop_valid. No bypass is needed: a popped entry was
  // always written on an earlier edge.
  assign pop_tag = pop_valid ? mem_rdata : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      pop_valid     <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      pop_valid <= popAcc;
      if (flush) begin
        // Memory contents are left stale. The error flags survive a flush.
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (pushAcc) tail <= tail + PTRWIDTH'(1);
        if (popAcc)  head <= head + PTRWIDTH'(1);
        if (pushAcc && !popAcc) begin
          count <= count + ADDRESSWIDTH'(1);
        end else if (popAcc && !pushAcc) begin
          count <= count - ADDRESSWIDTH'(1);
        end
        if (push && full)  err_overflow  <= 1'b1;
        if (pop && empty)  err_underflow <= 1'b1;
      end
    end
  end

endmodule
